// File: rtl/cpu7_csr_excp.sv
// Exception/interrupt CSR block: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/BSEC.
// Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) under `CPU7_CSR_TIMER_EN.
module cpu7_csr_excp #(
  parameter int GRLEN   = 32,
  parameter int HWI_NUM = 8,
  parameter int TIMER_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [13:0]      csr_raddr,
  output logic [GRLEN-1:0] csr_rdata,
  input  logic [13:0]      csr_waddr,
  input  logic [GRLEN-1:0] csr_wdata,
  input  logic             csr_wen,
  input  logic             ecl_csr_excp_e,
  input  logic [5:0]       ecl_csr_ecode_e,
  input  logic             ecl_csr_badv_vld_e,
  input  logic [GRLEN-1:0] ecl_csr_badv_e,
  input  logic [GRLEN-1:0] ifu_exu_pc_e,
  input  logic             ecl_csr_ertn_e,
  input  logic [HWI_NUM-1:0] hw_int,
  output logic [GRLEN-1:0] csr_eentry,
  output logic [GRLEN-1:0] csr_era,
  output logic             csr_int
);

  localparam logic [13:0] A_CRMD   = 14'h0;
  localparam logic [13:0] A_PRMD   = 14'h1;
  localparam logic [13:0] A_ECFG   = 14'h4;
  localparam logic [13:0] A_ESTAT  = 14'h5;
  localparam logic [13:0] A_ERA    = 14'h6;
  localparam logic [13:0] A_BADV   = 14'h7;
  localparam logic [13:0] A_EENTRY = 14'hc;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;
  localparam logic [13:0] A_BSEC   = 14'h100;

  logic             ie_q, ie_d, pie_q, pie_d, ef_q, ef_d;
  logic [1:0]       plv_q, plv_d, pplv_q, pplv_d, is_sw_q, is_sw_d;
  logic [11:0]      lie_q, lie_d;
  logic [5:0]       ecode_q, ecode_d;
  logic [HWI_NUM-1:0] hwi_q, hwi_d;
  logic [GRLEN-1:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d;
  logic             ti_q;
  logic [12:0]      is_full, lie_full;

  function automatic logic wr_hit(input logic [13:0] a);
    return csr_wen && (csr_waddr == a);
  endfunction

  // Architectural CSR next-state: exception > ertn > CSR write
  always_comb begin
    ie_d     = ie_q;
    plv_d    = plv_q;
    pie_d    = pie_q;
    pplv_d   = pplv_q;
    era_d    = era_q;
    badv_d   = badv_q;
    ecode_d  = ecode_q;
    is_sw_d  = is_sw_q;
    lie_d    = lie_q;
    eentry_d = eentry_q;
    ef_d     = ef_q;
    hwi_d    = hw_int;
    if (ecl_csr_excp_e) begin
      ie_d  = 1'b0;
      plv_d = 2'b00;
    end else if (ecl_csr_ertn_e) begin
      ie_d  = pie_q;
      plv_d = pplv_q;
    end else if (wr_hit(A_CRMD)) begin
      ie_d  = csr_wdata[2];
      plv_d = csr_wdata[1:0];
    end
    if (ecl_csr_excp_e) begin
      pie_d  = ie_q;
      pplv_d = plv_q;
    end else if (!ecl_csr_ertn_e && wr_hit(A_PRMD)) begin
      pie_d  = csr_wdata[2];
      pplv_d = csr_wdata[1:0];
    end
    if (ecl_csr_excp_e) begin
      era_d   = ifu_exu_pc_e;
      ecode_d = ecl_csr_ecode_e;
    end else if (wr_hit(A_ERA)) begin
      era_d = csr_wdata;
    end
    if (ecl_csr_excp_e && ecl_csr_badv_vld_e)
      badv_d = ecl_csr_badv_e;
    else if (wr_hit(A_BADV))
      badv_d = csr_wdata;
    if (wr_hit(A_ESTAT))  is_sw_d  = csr_wdata[1:0];
    if (wr_hit(A_ECFG))   lie_d    = csr_wdata[11:0];
    if (wr_hit(A_EENTRY)) eentry_d = csr_wdata;
    if (wr_hit(A_BSEC) && csr_wdata[0]) ef_d = 1'b1;
  end

  // Architectural CSR registers; reset overrides every other update
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q     <= 1'b0;
      plv_q    <= 2'b00;
      pie_q    <= 1'b0;
      pplv_q   <= 2'b00;
      era_q    <= '0;
      badv_q   <= '0;
      ecode_q  <= '0;
      is_sw_q  <= '0;
      lie_q    <= '0;
      eentry_q <= '0;
      ef_q     <= 1'b0;
      hwi_q    <= '0;
    end else begin
      ie_q     <= ie_d;
      plv_q    <= plv_d;
      pie_q    <= pie_d;
      pplv_q   <= pplv_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      ecode_q  <= ecode_d;
      is_sw_q  <= is_sw_d;
      lie_q    <= lie_d;
      eentry_q <= eentry_d;
      ef_q     <= ef_d;
      hwi_q    <= hwi_d;
    end
  end

`ifdef CPU7_CSR_TIMER_EN
  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d;
  logic               ti_d, ti_set;

  // Countdown, expiry/reload and TI set/clear; TCFG write beats expiry
  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    ti_set = 1'b0;
    if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TIMER_W'(1);
      end else begin
        ti_set = 1'b1;
        if (tcfg_q[1]) tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        else           tcfg_d[0] = 1'b0;
      end
    end
    if (wr_hit(A_TICLR) && csr_wdata[0]) ti_d = 1'b0;
    if (ti_set) ti_d = 1'b1;
    if (wr_hit(A_TCFG)) begin
      tcfg_d = csr_wdata[TIMER_W-1:0];
      tval_d = {csr_wdata[TIMER_W-1:2], 2'b00};
    end
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end
`else
  assign ti_q = 1'b0;
`endif

  // Pending/enable vectors and interrupt request
  always_comb begin
    is_full = '0;
    is_full[1:0] = is_sw_q;
    is_full[2 +: HWI_NUM] = hwi_q;
    is_full[11] = ti_q;
    lie_full = {1'b0, lie_q};
    csr_int = ie_q & (|(is_full & lie_full));
  end

  // Combinational CSR read mux
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      A_CRMD:   csr_rdata[2:0] = {ie_q, plv_q};
      A_PRMD:   csr_rdata[2:0] = {pie_q, pplv_q};
      A_ECFG:   csr_rdata[12:0] = lie_full;
      A_ESTAT: begin
        csr_rdata[12:0]  = is_full;
        csr_rdata[21:16] = ecode_q;
      end
      A_ERA:    csr_rdata = era_q;
      A_BADV:   csr_rdata = badv_q;
      A_EENTRY: csr_rdata = eentry_q;
      A_BSEC:   csr_rdata[0] = ef_q;
`ifdef CPU7_CSR_TIMER_EN
      A_TCFG:   csr_rdata = GRLEN'(tcfg_q);
      A_TVAL:   csr_rdata = GRLEN'(tval_q);
`endif
      default:  csr_rdata = '0;
    endcase
  end

  assign csr_eentry = eentry_q;
  assign csr_era    = era_q;

endmodule

// File: tb/tb_cpu7_csr_excp.sv
// Scoreboard bench for cpu7_csr_excp: directed stimulus pushes expected
// values, a monitor pops and compares on each sample strobe.
module tb_cpu7_csr_excp;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        excp;
  logic [5:0]  ecode;
  logic        bv;
  logic [31:0] badv;
  logic [31:0] pc;
  logic        ertn;
  logic [7:0]  hw_int;
  logic [31:0] eentry;
  logic [31:0] era;
  logic        irq;

  cpu7_csr_excp dut (
    .clk(clk), .rst(rst),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .ecl_csr_excp_e(excp), .ecl_csr_ecode_e(ecode),
    .ecl_csr_badv_vld_e(bv), .ecl_csr_badv_e(badv),
    .ifu_exu_pc_e(pc), .ecl_csr_ertn_e(ertn),
    .hw_int(hw_int),
    .csr_eentry(eentry), .csr_era(era), .csr_int(irq)
  );

  always #50 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic smp = 1'b0;

  // Monitor: on each sample strobe pop one expectation and compare
  always @(posedge smp) begin
    exp_t e;
    logic [31:0] act;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_underflow: sample with empty scoreboard");
    end else begin
      e = sb.pop_front();
      case (e.kind)
        0: act = csr_rdata;
        1: act = {31'd0, irq};
        2: act = era;
        default: act = eentry;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int k, input logic [31:0] x, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = x;
    e.name = n;
    sb.push_back(e);
    #1 smp = 1'b1;
    #1 smp = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] x,
                    input string n);
    csr_raddr = a;
    sample(0, x, n);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_waddr = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    step();
    csr_wen   = 1'b0;
  endtask

  task automatic take_excp(input logic [5:0] c, input logic [31:0] p,
                           input logic v, input logic [31:0] b,
                           input logic er);
    excp  = 1'b1;
    ecode = c;
    pc    = p;
    bv    = v;
    badv  = b;
    ertn  = er;
    step();
    excp = 1'b0;
    bv   = 1'b0;
    ertn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    csr_raddr = '0; csr_waddr = '0; csr_wdata = '0; csr_wen = 1'b0;
    excp = 1'b0; ecode = '0; bv = 1'b0; badv = '0; pc = '0;
    ertn = 1'b0; hw_int = '0;
    step();
    step();
    rst = 1'b0;

    rd(14'h0, 32'h0, "rst_crmd");
    rd(14'h1, 32'h0, "rst_prmd");
    rd(14'h5, 32'h0, "rst_estat");
    rd(14'h100, 32'h0, "rst_bsec");
    sample(1, 32'h0, "rst_int");
    sample(2, 32'h0, "rst_era");
    sample(3, 32'h0, "rst_eentry");

    wr(14'h0, 32'h7);
    rd(14'h0, 32'h7, "crmd_wr");
    take_excp(6'h08, 32'h1c000100, 1'b1, 32'hdead0000, 1'b0);
    rd(14'h0, 32'h0, "excp_crmd");
    rd(14'h1, 32'h7, "excp_prmd");
    rd(14'h6, 32'h1c000100, "excp_era");
    rd(14'h5, 32'h00080000, "excp_estat");
    rd(14'h7, 32'hdead0000, "excp_badv");
    sample(2, 32'h1c000100, "excp_era_port");

    ertn = 1'b1;
    step();
    ertn = 1'b0;
    rd(14'h0, 32'h7, "ertn_crmd");
    rd(14'h1, 32'h7, "ertn_prmd");

    take_excp(6'h08, 32'h1c000200, 1'b0, 32'h11111111, 1'b1);
    rd(14'h0, 32'h0, "excp_ertn_crmd");
    rd(14'h1, 32'h7, "excp_ertn_prmd");
    rd(14'h6, 32'h1c000200, "excp_ertn_era");
    rd(14'h7, 32'hdead0000, "badv_hold");

    csr_waddr = 14'h6;
    csr_wdata = 32'h00001234;
    csr_wen   = 1'b1;
    take_excp(6'h0b, 32'h1c000300, 1'b0, 32'h0, 1'b0);
    csr_wen   = 1'b0;
    rd(14'h6, 32'h1c000300, "excp_over_wr_era");
    rd(14'h5, 32'h000b0000, "excp_ecode2");
    rd(14'h1, 32'h0, "excp_prmd2");

    wr(14'h4, 32'h00001004);
    rd(14'h4, 32'h00000004, "ecfg_lie");
    wr(14'h0, 32'h4);
    hw_int = 8'h01;
    sample(1, 32'h0, "int_latency");
    step();
    rd(14'h5, 32'h000b0004, "estat_hwi");
    sample(1, 32'h1, "int_set");
    wr(14'h0, 32'h0);
    sample(1, 32'h0, "int_ie_clr");

    hw_int = 8'h00;
    wr(14'h5, 32'hffffffff);
    rd(14'h5, 32'h000b0003, "estat_sw_only");

    wr(14'hc, 32'h1c008000);
    sample(3, 32'h1c008000, "eentry_port");
    rd(14'hc, 32'h1c008000, "eentry_rd");

    wr(14'h100, 32'h1);
    wr(14'h100, 32'h0);
    rd(14'h100, 32'h1, "bsec_sticky");
    rd(14'h3, 32'h0, "unmapped");

`ifdef CPU7_CSR_TIMER_EN
    wr(14'h41, 32'h13);
    rd(14'h42, 32'd16, "tval_load");
    rd(14'h41, 32'h13, "tcfg_rd");
    for (int i = 15; i >= 0; i--) begin
      step();
      rd(14'h42, 32'(i), "tval_count");
    end
    step();
    rd(14'h5, 32'h000b0803, "ti_set");
    rd(14'h42, 32'd16, "tval_reload");
    wr(14'h44, 32'h1);
    rd(14'h5, 32'h000b0003, "ti_clr");
    rd(14'h44, 32'h0, "ticlr_rd");
`else
    wr(14'h41, 32'h13);
    rd(14'h41, 32'h0, "tcfg_off");
    rd(14'h42, 32'h0, "tval_off");
    step();
    rd(14'h5, 32'h000b0003, "ti_off");
`endif

    step();
    step();
    rst  = 1'b1;
    excp = 1'b1;
    pc   = 32'h00000055;
    step();
    rst  = 1'b0;
    excp = 1'b0;
    rd(14'h0, 32'h0, "rst2_crmd");
    rd(14'h1, 32'h0, "rst2_prmd");
    rd(14'h4, 32'h0, "rst2_ecfg");
    rd(14'h5, 32'h0, "rst2_estat");
    rd(14'h7, 32'h0, "rst2_badv");
    rd(14'h100, 32'h0, "rst2_bsec");
    rd(14'h41, 32'h0, "rst2_tcfg");
    rd(14'h42, 32'h0, "rst2_tval");
    sample(1, 32'h0, "rst2_int");
    sample(2, 32'h0, "rst2_era");
    sample(3, 32'h0, "rst2_eentry");

    for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
